// File: rtl/wb_shared_arbiter.sv
// wb_shared_arbiter: shares one pipelined Wishbone downstream port between NUM_CTRL
// upstream controllers with round-robin ownership, an outstanding-request limit and
// local error responses for unmapped addresses.
// Optional feature: define WB_TIMEOUT_EN to abort a stuck bus after TIMEOUT_CYCLES.
module wb_shared_arbiter #(
    parameter int unsigned NUM_CTRL        = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [15:0] PERI_MASK       = 16'h0112,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_CTRL-1:0]     i_c_cyc,
    input  logic [NUM_CTRL-1:0]     i_c_stb,
    input  logic [NUM_CTRL-1:0]     i_c_we,
    input  logic [NUM_CTRL*32-1:0]  i_c_adr,
    input  logic [NUM_CTRL*32-1:0]  i_c_dat_w,
    input  logic [NUM_CTRL*4-1:0]   i_c_sel,
    output logic [NUM_CTRL-1:0]     o_c_stall,
    output logic [NUM_CTRL-1:0]     o_c_ack,
    output logic [NUM_CTRL-1:0]     o_c_err,
    output logic [31:0]             o_c_dat_r,
    output logic                    o_p_cyc,
    output logic                    o_p_stb,
    output logic                    o_p_we,
    output logic [31:0]             o_p_adr,
    output logic [31:0]             o_p_dat_w,
    output logic [3:0]              o_p_sel,
    input  logic                    i_p_stall,
    input  logic                    i_p_ack,
    input  logic                    i_p_err,
    input  logic [31:0]             i_p_dat_r
);

    localparam int unsigned OW = $clog2(NUM_CTRL);
    localparam int unsigned CW = 4;

    typedef logic [OW-1:0] idx_t;

    typedef enum logic [1:0] {
        StIdle,
        StOwned,
        StUnmapErr,
        StDrain
    } state_t;

    // Reject illegal configurations at elaboration.
    if (NUM_CTRL < 2 || NUM_CTRL > 8) begin : g_bad_num_ctrl
        $error("NUM_CTRL must be 2..8");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_max_out
        $error("MAX_OUTSTANDING must be 1..15");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t        state_q, state_d;
    idx_t          owner_q, owner_d;
    idx_t          rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          grant_found;
    idx_t          grant_idx;

    logic          own_cyc, own_stb, own_mapped, own_stall, cnt_full, resp, accepted;
    logic [31:0]   own_adr;

    assign own_cyc    = i_c_cyc[owner_q];
    assign own_stb    = i_c_stb[owner_q];
    assign own_adr    = i_c_adr[{owner_q, 5'b0} +: 32];
    assign own_mapped = PERI_MASK[own_adr[31:28]];
    assign cnt_full   = (cnt_q == CW'(MAX_OUTSTANDING));

    // Read data is a plain pass-through; only the ack qualifies it.
    assign o_c_dat_r = i_p_dat_r;

`ifdef WB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          timeout;

    // Timeout timer register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    // Round-robin search starting at the slot after the previous owner.
    always_comb begin
        int unsigned j;
        j           = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 0; i < NUM_CTRL; i++) begin
            j = (int'(rr_ptr_q) + i) % NUM_CTRL;
            if (!grant_found && i_c_cyc[j]) begin
                grant_found = 1'b1;
                grant_idx   = idx_t'(j);
            end
        end
    end

    // Next-state, counter and bus output logic.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        o_c_stall = '1;
        o_c_ack   = '0;
        o_c_err   = '0;
        o_p_cyc   = 1'b0;
        o_p_stb   = 1'b0;
        o_p_we    = i_c_we[owner_q];
        o_p_adr   = own_adr;
        o_p_dat_w = i_c_dat_w[{owner_q, 5'b0} +: 32];
        o_p_sel   = i_c_sel[{owner_q, 2'b0} +: 4];
        own_stall = 1'b1;
        resp      = 1'b0;
        accepted  = 1'b0;
`ifdef WB_TIMEOUT_EN
        timer_d   = '0;
        timeout   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (grant_found) begin
                    owner_d  = grant_idx;
                    rr_ptr_d = (grant_idx == idx_t'(NUM_CTRL - 1)) ? '0 : grant_idx + 1'b1;
                    state_d  = StOwned;
                end
            end
            StOwned: begin
                if (!own_cyc) begin
                    // Abandon anything in flight; late responses fall on IDLE.
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    o_p_cyc = 1'b1;
                    // Responses with nothing outstanding are stray and dropped.
                    if (cnt_q != '0) begin
                        o_c_ack[owner_q] = i_p_ack;
                        o_c_err[owner_q] = i_p_err;
                        resp             = i_p_ack | i_p_err;
                    end
                    if (own_stb && !own_mapped) begin
                        // Unmapped access waits for the bus to drain, then errors locally.
                        own_stall = (cnt_q != '0);
                        if (cnt_q == '0) begin
                            state_d = StUnmapErr;
                        end
                    end else begin
                        own_stall = cnt_full | i_p_stall;
                        o_p_stb   = own_stb & ~cnt_full;
                        accepted  = own_stb & ~own_stall;
                    end
                    o_c_stall[owner_q] = own_stall;
                    cnt_d = cnt_q + CW'(accepted) - CW'(resp);
`ifdef WB_TIMEOUT_EN
                    timeout = (cnt_q != '0) && !resp && (timer_q == TW'(TIMEOUT_CYCLES - 1));
                    if (cnt_q != '0 && !resp) begin
                        timer_d = timer_q + 1'b1;
                    end
                    if (timeout) begin
                        o_p_cyc            = 1'b0;
                        o_p_stb            = 1'b0;
                        o_c_stall[owner_q] = 1'b1;
                        o_c_ack            = '0;
                        o_c_err[owner_q]   = 1'b1;
                        cnt_d              = '0;
                        timer_d            = '0;
                        state_d            = StDrain;
                    end
`endif
                end
            end
            StUnmapErr: begin
                if (own_cyc) begin
                    o_c_err[owner_q] = 1'b1;
                    state_d          = StOwned;
                end else begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (!own_cyc) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, ownership, round-robin pointer and outstanding counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: doc/wb_shared_arbiter.md
WB_SHARED_ARBITER -- requirements
Module: wb_shared_arbiter

Interface
REQ-001 SHALL have parameter NUM_CTRL, default 2: number of upstream pipelined Wishbone controllers (2..8).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4: maximum accepted-but-unacknowledged requests (1..15).
REQ-003 SHALL have parameter PERI_MASK, default 16'h0112: bit k set means adr[31:28]==k is mapped downstream.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255: cycles without ack/err before abort (only with WB_TIMEOUT_EN).
REQ-005 SHALL have port i_clk, input, 1: single clock, all state on rising edge.
REQ-006 SHALL have port i_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have ports i_c_cyc, i_c_stb, i_c_we, input, NUM_CTRL each: per-controller Wishbone cycle, strobe, write.
REQ-008 SHALL have ports i_c_adr, i_c_dat_w, input, NUM_CTRL*32 each: packed address and write data, controller n at [n*32+:32].
REQ-009 SHALL have port i_c_sel, input, NUM_CTRL*4: packed byte selects.
REQ-010 SHALL have ports o_c_stall, o_c_ack, o_c_err, output, NUM_CTRL each: per-controller stall, ack, error.
REQ-011 SHALL have port o_c_dat_r, output, 32: read data, shared, valid with o_c_ack.
REQ-012 SHALL have ports o_p_cyc, o_p_stb, o_p_we (1), o_p_adr, o_p_dat_w (32), o_p_sel (4), output: downstream bus.
REQ-013 SHALL have ports i_p_stall, i_p_ack, i_p_err (1), i_p_dat_r (32), input: downstream responses.

Function
REQ-014 SHALL implement states IDLE, OWNED, UNMAP_ERR, DRAIN.
REQ-015 IDLE: o_p_cyc=0, all o_c_stall=1; any i_c_cyc set -> grant registered, OWNED next cycle (1-cycle arbitration latency).
REQ-016 SHALL arbitrate round-robin: search starts at last owner+1 modulo NUM_CTRL; pointer is 0 after reset.
REQ-017 OWNED: o_p_cyc=1; owner cyc/stb/we/adr/dat_w/sel forwarded combinationally; o_c_stall[owner]=i_p_stall.
REQ-018 Non-owners SHALL see stall=1, ack=0, err=0 at all times.
REQ-019 ack/err SHALL route only to owner; o_c_dat_r=i_p_dat_r, zero cycle latency.
REQ-020 Outstanding counter: +1 on accepted stb (stb & !stall), -1 on ack or err; both same cycle -> unchanged.
REQ-021 Counter==MAX_OUTSTANDING SHALL force owner stall=1 and o_p_stb=0.
REQ-022 Owner stb with adr[31:28] not in PERI_MASK: o_p_stb=0; stall held 1 until counter==0, then accepted, state UNMAP_ERR.
REQ-023 UNMAP_ERR: o_c_err[owner]=1 for exactly one cycle, then OWNED.
REQ-024 Owner drops cyc in OWNED: counter cleared, o_p_cyc=0 same cycle, state IDLE; late downstream ack/err ignored.
REQ-025 Acks arriving with counter==0 SHALL be ignored (no o_c_ack).
REQ-026 DRAIN: o_p_cyc=0, owner stall=1, no ack/err; exit to IDLE when owner drops cyc.

Reset
REQ-027 i_rst_n low SHALL immediately force state IDLE, counter 0, rr pointer 0, o_p_cyc=o_p_stb=0, all o_c_ack=o_c_err=0, all o_c_stall=1.
REQ-028 Reset mid-transaction SHALL abandon outstanding requests; no response after release.

Configuration
REQ-029 Macro WB_TIMEOUT_EN defined: cycle counter runs while counter>0 in OWNED, clears on any ack/err; reaching TIMEOUT_CYCLES -> one-cycle o_c_err to owner, counter cleared, o_p_cyc=0, state DRAIN.
REQ-030 WB_TIMEOUT_EN undefined: no timer logic, DRAIN unreachable, OWNED waits indefinitely.

Verification
REQ-031 Ctrl0 and ctrl1 raise cyc same cycle after reset -> ctrl0 owns; ctrl0 drops cyc -> ctrl1 owns 2 cycles later (IDLE, then OWNED).
REQ-032 Ctrl0 issues 6 back-to-back reads to 0x4000_0000, peripheral ack delayed 7 cycles -> 5th stb stalled until first ack, 6 acks to ctrl0 in order, ctrl1 sees no ack.
REQ-033 Read to 0x2000_0000 with 2 outstanding -> stall until both acked, then single o_c_err pulse, no o_p_stb.
REQ-034 Owner drops cyc with 3 outstanding; peripheral acks 2 cycles later -> no o_c_ack on any controller.
REQ-035 With WB_TIMEOUT_EN, TIMEOUT_CYCLES=16, peripheral never acks -> o_c_err exactly 16 cycles after stb acceptance, o_p_cyc low, stall=1 until cyc drops.
REQ-036 i_rst_n pulsed low mid-burst -> outputs at reset values asynchronously, ctrl0 wins next arbitration.
